// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: packet-locked round-robin arbiter that shares one UART
// transmitter between NUM_REQ byte-stream requesters. A granted requester
// keeps the transmitter until its byte marked last has been sent, or until
// it leaves valid low in HOLD for HOLD_TIMEOUT cycles.
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int HOLD_TIMEOUT = 1024,
  localparam int GW          = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 uart_start,
  output logic [7:0]           uart_data,
  input  logic                 uart_done,
  output logic                 busy,
  output logic [GW-1:0]        grant_id,
  output logic                 timeout_err
);

  // Hold timer only needs to count up to HOLD_TIMEOUT-1.
  localparam int TW = (HOLD_TIMEOUT > 1) ? $clog2(HOLD_TIMEOUT) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'(HOLD_TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [GW-1:0]   owner_q, owner_d;
  logic [GW-1:0]   ptr_q, ptr_d;
  logic [7:0]      data_q, data_d;
  logic            last_q, last_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            timeout_q, timeout_d;
  logic            start_q;
  logic            busy_q;

  logic            win_found;
  logic [GW-1:0]   win_idx;
  logic [GW-1:0]   cand;
  logic [GW-1:0]   sel_idx;
  logic [7:0]      sel_data;

  // Round-robin winner: first valid requester searching upward from ptr+1.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = GW'((int'(ptr_q) + k) % NUM_REQ);
      if (!win_found && req_valid[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // Byte source: the locked owner in HOLD, otherwise the arbitration winner.
  assign sel_idx  = (state_q == HOLD) ? owner_q : win_idx;
  assign sel_data = req_data[{sel_idx, 3'b000} +: 8];

  // Combinational one-hot ready; held low while reset is asserted.
  always_comb begin
    req_ready = '0;
    if (!rst) begin
      if (state_q == IDLE && win_found) begin
        req_ready[win_idx] = 1'b1;
      end else if (state_q == HOLD) begin
        req_ready[owner_q] = 1'b1;
      end
    end
  end

  // Next-state logic: arbitration, byte latch, packet lock and hold timeout.
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    ptr_d     = ptr_q;
    data_d    = data_q;
    last_d    = last_q;
    timer_d   = timer_q;
    timeout_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (win_found) begin
          data_d  = sel_data;
          last_d  = req_last[win_idx];
          owner_d = win_idx;
          state_d = START;
        end
      end
      START: begin
        state_d = WAIT;
      end
      WAIT: begin
        if (uart_done) begin
          if (last_q) begin
            ptr_d   = owner_q;
            state_d = IDLE;
          end else begin
            timer_d = '0;
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (req_valid[owner_q]) begin
          data_d  = sel_data;
          last_d  = req_last[owner_q];
          timer_d = '0;
          state_d = START;
        end else if (timer_q == TO_LAST) begin
          timeout_d = 1'b1;
          ptr_d     = owner_q;
          state_d   = IDLE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs; reset parks in IDLE with requester 0 first.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      owner_q   <= '0;
      ptr_q     <= GW'(NUM_REQ - 1);
      data_q    <= '0;
      last_q    <= 1'b0;
      timer_q   <= '0;
      timeout_q <= 1'b0;
      start_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      ptr_q     <= ptr_d;
      data_q    <= data_d;
      last_q    <= last_d;
      timer_q   <= timer_d;
      timeout_q <= timeout_d;
      start_q   <= (state_d == START);
      busy_q    <= (state_d != IDLE);
    end
  end

  assign uart_start  = start_q;
  assign uart_data   = data_q;
  assign busy        = busy_q;
  assign grant_id    = owner_q;
  assign timeout_err = timeout_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed scenarios plus packet streams checked
// against a queue-based round-robin reference model.
module tb_uart_tx_arbiter;

  localparam int N  = 4;
  localparam int HT = 8;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req_valid = '0;
  logic [8*N-1:0] req_data = '0;
  logic [N-1:0]   req_last = '0;
  logic           uart_done = 1'b0;
  logic [N-1:0]   req_ready;
  logic           uart_start;
  logic [7:0]     uart_data;
  logic           busy;
  logic [1:0]     grant_id;
  logic           timeout_err;

  int vectors = 0;
  int miscompares = 0;

  // Packet store per requester and expected UART stream.
  logic [7:0] qd [N][16];
  logic       ql [N][16];
  int         qc [N];
  int         qh [N];
  logic [7:0] exp_d [$];
  int         exp_o [$];

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NUM_REQ(N), .HOLD_TIMEOUT(HT)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .uart_start(uart_start),
    .uart_data(uart_data), .uart_done(uart_done), .busy(busy),
    .grant_id(grant_id), .timeout_err(timeout_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [7:0] d, input logic l);
    req_valid[i]       = v;
    req_data[8*i +: 8] = d;
    req_last[i]        = l;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    uart_done = 1'b0;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  task automatic pulse_done();
    uart_done = 1'b1;
    cyc();
    uart_done = 1'b0;
  endtask

  task automatic q_clear();
    for (int i = 0; i < N; i++) begin
      qc[i] = 0;
      qh[i] = 0;
    end
  endtask

  task automatic add_pkt(input int r, input int len);
    for (int k = 0; k < len; k++) begin
      qd[r][qc[r]] = 8'($urandom);
      ql[r][qc[r]] = (k == len - 1);
      qc[r]++;
    end
  endtask

  // Reference: after reset the last owner is N-1; each packet goes to the
  // next requester (cyclically after the last owner) that still has one.
  task automatic build_model();
    int  h [N];
    int  p;
    int  r;
    bit  any;
    exp_d.delete();
    exp_o.delete();
    for (int i = 0; i < N; i++) h[i] = 0;
    p = N - 1;
    do begin
      any = 1'b0;
      for (int k = 1; k <= N && !any; k++) begin
        r = (p + k) % N;
        if (h[r] < qc[r]) begin
          any = 1'b1;
          p   = r;
          do begin
            exp_d.push_back(qd[r][h[r]]);
            exp_o.push_back(r);
            h[r]++;
          end while (!ql[r][h[r]-1]);
        end
      end
    end while (any);
  endtask

  // Requesters present their queued bytes whenever they have one; a UART
  // model answers every start with a done pulse after a random delay.
  task automatic run_engine(input string tag);
    int         n_acc;
    int         n_sent;
    int         cd;
    int         guard;
    logic [N-1:0] hs;
    logic [N-1:0] exp_rdy;
    build_model();
    n_acc = 0; n_sent = 0; cd = 0; guard = 0;
    while (!(n_sent == exp_d.size() && cd == 0 && !busy) && guard < 4000) begin
      guard++;
      for (int i = 0; i < N; i++) begin
        if (qh[i] < qc[i]) set_req(i, 1'b1, qd[i][qh[i]], ql[i][qh[i]]);
        else               set_req(i, 1'b0, 8'h00, 1'b0);
      end
      uart_done = 1'b0;
      if (cd > 0) begin
        cd--;
        if (cd == 0) uart_done = 1'b1;
      end
      #1;
      exp_rdy = (n_acc < exp_d.size()) ? N'(1 << exp_o[n_acc]) : '0;
      if (req_ready != '0) check({tag, "_rdy"}, 32'(req_ready), 32'(exp_rdy));
      hs = req_valid & req_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (hs[i]) begin
          qh[i]++;
          n_acc++;
        end
      end
      if (uart_start) begin
        if (n_sent < exp_d.size()) begin
          check({tag, "_data"}, 32'(uart_data), 32'(exp_d[n_sent]));
          check({tag, "_gnt"}, 32'(grant_id), 32'(exp_o[n_sent]));
        end else begin
          check({tag, "_extra_start"}, 32'(uart_start), 32'd0);
        end
        n_sent++;
        cd = $urandom_range(10, 2);
      end
    end
    uart_done = 1'b0;
    req_valid = '0;
    req_last  = '0;
    check({tag, "_bytes"}, 32'(n_sent), 32'(exp_d.size()));
    check({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    // Reset values
    rst = 1'b1;
    cyc();
    cyc();
    check("rst_start", 32'(uart_start), 32'd0);
    check("rst_data", 32'(uart_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_gnt", 32'(grant_id), 32'd0);
    check("rst_to", 32'(timeout_err), 32'd0);
    check("rst_rdy", 32'(req_ready), 32'd0);
    rst = 1'b0;

    // Single byte from requester 0
    set_req(0, 1'b1, 8'h41, 1'b1);
    #1;
    check("t1_rdy", 32'(req_ready), 32'h1);
    cyc();
    check("t1_start", 32'(uart_start), 32'd1);
    check("t1_data", 32'(uart_data), 32'h41);
    check("t1_busy", 32'(busy), 32'd1);
    check("t1_gnt", 32'(grant_id), 32'd0);
    check("t1_rdy_start", 32'(req_ready), 32'd0);
    set_req(0, 1'b0, 8'h00, 1'b0);
    cyc();
    check("t1_start_once", 32'(uart_start), 32'd0);
    check("t1_busy_wait", 32'(busy), 32'd1);
    repeat (8) cyc();
    pulse_done();
    check("t1_idle", 32'(busy), 32'd0);
    check("t1_gnt_hold", 32'(grant_id), 32'd0);

    // Two 3-byte packets, requesters 1 and 2 together
    do_reset();
    q_clear();
    add_pkt(1, 3);
    add_pkt(2, 3);
    run_engine("t2");

    // Round robin over four single-byte streams
    do_reset();
    q_clear();
    for (int i = 0; i < N; i++) begin
      add_pkt(i, 1);
      add_pkt(i, 1);
    end
    run_engine("t3");

    // Hold timeout, then pending requester 1 is served
    do_reset();
    set_req(0, 1'b1, 8'h10, 1'b0);
    set_req(1, 1'b1, 8'h22, 1'b1);
    #1;
    check("t4_rdy0", 32'(req_ready), 32'h1);
    cyc();
    check("t4_data0", 32'(uart_data), 32'h10);
    set_req(0, 1'b0, 8'h00, 1'b0);
    cyc();
    repeat (3) cyc();
    pulse_done();
    #1;
    check("t4_hold_rdy", 32'(req_ready), 32'h1);
    for (int k = 0; k < HT; k++) begin
      check("t4_no_to", 32'(timeout_err), 32'd0);
      check("t4_hold_busy", 32'(busy), 32'd1);
      if (k < HT - 1) cyc();
    end
    cyc();
    check("t4_to", 32'(timeout_err), 32'd1);
    check("t4_to_idle", 32'(busy), 32'd0);
    #1;
    check("t4_rdy1", 32'(req_ready), 32'h2);
    cyc();
    check("t4_to_once", 32'(timeout_err), 32'd0);
    check("t4_start1", 32'(uart_start), 32'd1);
    check("t4_data1", 32'(uart_data), 32'h22);
    check("t4_gnt1", 32'(grant_id), 32'd1);
    set_req(1, 1'b0, 8'h00, 1'b0);
    cyc();
    repeat (2) cyc();
    pulse_done();
    check("t4_end", 32'(busy), 32'd0);

    // Reset while waiting on the UART
    set_req(2, 1'b1, 8'h33, 1'b1);
    #1;
    check("t5_rdy2", 32'(req_ready), 32'h4);
    cyc();
    check("t5_gnt2", 32'(grant_id), 32'd2);
    set_req(2, 1'b0, 8'h00, 1'b0);
    cyc();
    check("t5_wait", 32'(busy), 32'd1);
    rst = 1'b1;
    cyc();
    check("t5_start", 32'(uart_start), 32'd0);
    check("t5_data", 32'(uart_data), 32'd0);
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_gnt", 32'(grant_id), 32'd0);
    check("t5_to", 32'(timeout_err), 32'd0);
    check("t5_rdy", 32'(req_ready), 32'd0);
    rst = 1'b0;
    pulse_done();
    check("t5_late_done", 32'(busy), 32'd0);
    cyc();
    check("t5_no_start", 32'(uart_start), 32'd0);
    set_req(0, 1'b1, 8'h44, 1'b1);
    set_req(2, 1'b1, 8'h55, 1'b1);
    #1;
    check("t5_rdy0", 32'(req_ready), 32'h1);
    cyc();
    check("t5_gnt0", 32'(grant_id), 32'd0);
    check("t5_data0", 32'(uart_data), 32'h44);
    set_req(0, 1'b0, 8'h00, 1'b0);
    set_req(2, 1'b0, 8'h00, 1'b0);
    cyc();
    pulse_done();
    check("t5_end", 32'(busy), 32'd0);

    // Spurious done in IDLE and in HOLD
    pulse_done();
    check("t6_idle_busy", 32'(busy), 32'd0);
    check("t6_idle_start", 32'(uart_start), 32'd0);
    cyc();
    check("t6_idle_start2", 32'(uart_start), 32'd0);
    set_req(3, 1'b1, 8'h66, 1'b0);
    cyc();
    check("t6_gnt3", 32'(grant_id), 32'd3);
    check("t6_data_a", 32'(uart_data), 32'h66);
    set_req(3, 1'b0, 8'h00, 1'b0);
    cyc();
    pulse_done();
    check("t6_hold", 32'(busy), 32'd1);
    pulse_done();
    check("t6_hold_busy", 32'(busy), 32'd1);
    check("t6_hold_start", 32'(uart_start), 32'd0);
    #1;
    check("t6_hold_rdy", 32'(req_ready), 32'h8);
    set_req(3, 1'b1, 8'h77, 1'b1);
    cyc();
    check("t6_start_b", 32'(uart_start), 32'd1);
    check("t6_data_b", 32'(uart_data), 32'h77);
    set_req(3, 1'b0, 8'h00, 1'b0);
    cyc();
    pulse_done();
    check("t6_end", 32'(busy), 32'd0);

    // Random packet mixes
    for (int it = 0; it < 4; it++) begin
      int total;
      do_reset();
      q_clear();
      total = 0;
      for (int r = 0; r < N; r++) begin
        int np;
        np = $urandom_range(3, 0);
        for (int p = 0; p < np; p++) begin
          add_pkt(r, $urandom_range(4, 1));
          total++;
        end
      end
      if (total == 0) add_pkt(0, 2);
      run_engine("rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares the single UART transmitter between NUM_REQ byte-stream requesters using packet-locked round-robin arbitration. It accepts one byte at a time over valid/ready, pulses the UART start strobe, and waits for the UART done pulse before taking the next byte. Once a requester is granted, it keeps the grant until its byte marked last has been sent, so packets are never interleaved. It sits between the SoC-side producers (console, debug dump, inference-result reporter) and the UART TX start/data/done interface.

Parameters:
NUM_REQ, 4, number of requesters; legal range 2..8.
HOLD_TIMEOUT, 1024, clock cycles a locked owner may leave req_valid low between bytes before its grant is revoked; must be at least 1.
GW, $clog2(NUM_REQ), width of grant_id (derived; not overridden).

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
req_valid  input  NUM_REQ  per-requester byte valid
req_data  input  8*NUM_REQ  per-requester byte; requester i uses bits [8i+7:8i]
req_last  input  NUM_REQ  byte is the final byte of the requester's packet
req_ready  output  NUM_REQ  one-hot accept strobe; a byte transfers when valid and ready are both high
uart_start  output  1  one-cycle start pulse to UART TX
uart_data  output  8  byte to transmit; held stable from the start pulse until done
uart_done  input  1  one-cycle pulse from UART TX when the stop bit completes
busy  output  1  high in every state except IDLE
grant_id  output  GW  current or most recent owner index
timeout_err  output  1  one-cycle pulse when a locked owner's grant is revoked by timeout

Behaviour:
- States: IDLE, START, WAIT, HOLD. All outputs are registered except req_ready, which is combinational from state, owner and the round-robin winner.
- Reset (synchronous, any state): state becomes IDLE. uart_start=0, uart_data=0, busy=0, grant_id=0, timeout_err=0, req_ready=0. The round-robin pointer resets so requester 0 has highest priority. Any byte in flight is abandoned, and no further start is issued.
- IDLE:
  - Winner = the first asserted req_valid searching upward from (ptr+1) mod NUM_REQ; after reset the search starts at 0.
  - req_ready[winner] is high in the same cycle, so the transfer completes that cycle.
  - On transfer: latch data into uart_data, latch req_last, set owner=grant_id=winner, go to START.
  - If no req_valid is asserted, stay in IDLE with req_ready=0.
- START: uart_start=1 for exactly this cycle, then go to WAIT. The byte is therefore accepted in cycle T and uart_start is high in cycle T+1.
- WAIT:
  - req_ready=0.
  - On uart_done: if the latched last is 1, set ptr=owner (the finished owner becomes lowest priority) and go to IDLE. Otherwise clear the hold timer and go to HOLD.
  - There is no timeout in WAIT; the UART always completes.
- HOLD:
  - req_ready[owner]=1 and all other ready bits are 0; valid from other requesters is ignored.
  - If req_valid[owner] is high: transfer, latch data and last, clear the timer, go to START.
  - Otherwise increment the timer. When the timer reaches HOLD_TIMEOUT-1 with no valid, pulse timeout_err for one cycle, set ptr=owner, and go to IDLE.
- uart_done outside WAIT is ignored.
- Simultaneous requests: only the winner sees ready. Losers keep valid asserted; the arbiter never drops a pending request.
- req_valid deasserted by a requester in the same cycle ready would have risen: no transfer occurs.
- grant_id holds its value in IDLE (it shows the last owner).
- Throughput: at most one byte per UART frame, plus 2 cycles of arbiter overhead (accept and start).

Test Plan:
1. Reset, then req_valid=4'b0001, data 0x41, last=1. Required: ready[0] high in that cycle, uart_start high next cycle with uart_data=0x41. A uart_done pulse 10 cycles later returns the block to IDLE with busy=0.
2. Requesters 1 and 2 each send a 3-byte packet; both assert valid at the same cycle after reset. Required: UART byte order is req1 b0,b1,b2 then req2 b0,b1,b2. ready[2] stays 0 throughout req1's packet.
3. Round-robin fairness: all four requesters continuously send single-byte packets (last=1). Required: grant_id sequence is 0,1,2,3,0,1.
4. HOLD_TIMEOUT=8: req0 sends byte 0x10 with last=0, then drops valid. Required: after 8 cycles in HOLD, timeout_err pulses once and the block returns to IDLE. A pending req1 is then granted.
5. rst asserted in WAIT after uart_start. Required: the next cycle shows all outputs zero and state IDLE. A later uart_done causes no action, and the next grant goes to requester 0 if it is valid.
6. A spurious uart_done pulse in IDLE or HOLD. Required: no state change and no uart_start.
